// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_ARMED = 2'd2
  } state_t;

  localparam logic OVERLAP     = 1'b1;
  localparam logic NON_OVERLAP = 1'b0;

  // Width needed to hold a pattern length of 0..w.
  function automatic int len_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with a clear input that takes priority over increment.
module seq_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset)                      value <= '0;
    else if (clr)                   value <= '0;
    else if (inc && (value != '1))  value <= value + 1'b1;
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-sequence detector with registered match pulse.
// Define SEQDET_LAST_POS_EN to add the last_pos output (index of the latest match's final bit).
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int POS_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic                          in_bit,
  input  logic                          cfg_load,
  input  logic [PAT_W-1:0]              cfg_pattern,
  input  logic [len_width(PAT_W)-1:0]   cfg_len,
  input  logic                          cfg_overlap,
  input  logic                          cnt_clear,
  output logic                          match,
  output logic [CNT_W-1:0]              match_count,
  output logic                          cfg_err,
`ifdef SEQDET_LAST_POS_EN
  output logic [POS_W-1:0]              last_pos,
`endif
  output logic                          armed
);

  localparam int LEN_W = len_width(PAT_W);

  state_t             state, state_n;
  // The newest bit comes straight from in_bit, so only PAT_W-1 older bits are kept.
  logic [PAT_W-2:0]   hist;
  logic [PAT_W-1:0]   hist_n, pattern, mask;
  logic [LEN_W-1:0]   len, fill, fill_n;
  logic               overlap, cfg_ok, accept, hit;

  always_comb begin
    cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    accept = in_valid && !cfg_load && (state != S_IDLE);
    hist_n = {hist, in_bit};
    fill_n = (fill == len) ? len : fill + LEN_W'(1);
    mask   = ~({PAT_W{1'b1}} << len);
    hit    = accept && (fill_n == len) && (((hist_n ^ pattern) & mask) == '0);
  end

  always_comb begin
    state_n = state;
    if (cfg_load) begin
      if (cfg_ok) state_n = S_FILL;
    end else if (accept) begin
      if (hit && (overlap == NON_OVERLAP)) state_n = S_FILL;
      else if (fill_n == len)              state_n = S_ARMED;
      else                                 state_n = S_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= '0;
      len     <= '0;
      overlap <= OVERLAP;
      match   <= 1'b0;
      cfg_err <= 1'b0;
      armed   <= 1'b0;
    end else begin
      match   <= hit;
      cfg_err <= cfg_load && !cfg_ok;
      armed   <= (state_n == S_ARMED);
      if (cfg_load) begin
        if (cfg_ok) begin
          pattern <= cfg_pattern;
          len     <= cfg_len;
          overlap <= cfg_overlap;
          hist    <= '0;
          fill    <= '0;
        end
      end else if (accept) begin
        hist <= hist_n[PAT_W-2:0];
        // Non-overlapping mode needs a full fresh pattern after each hit.
        fill <= (hit && (overlap == NON_OVERLAP)) ? '0 : fill_n;
      end
    end
  end

  seq_sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .clr   (cnt_clear),
    .value (match_count)
  );

`ifdef SEQDET_LAST_POS_EN
  logic [POS_W-1:0] pos_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_cnt  <= '0;
      last_pos <= '0;
    end else begin
      if (cfg_load) begin
        if (cfg_ok) pos_cnt <= '0;
      end else if (accept) begin
        pos_cnt <= pos_cnt + 1'b1;
      end
      if (hit) last_pos <= pos_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: vector table, directed corner sequences and random stream vs a queue model.
module tb_seq_detector_param;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int POS_W = 16;
  localparam int LW    = $clog2(PAT_W + 1);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_bit, cfg_load, cfg_overlap, cnt_clear;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LW-1:0]    cfg_len;
  logic             match, cfg_err, armed;
  logic [CNT_W-1:0] match_count;
`ifdef SEQDET_LAST_POS_EN
  logic [POS_W-1:0] last_pos;
`endif

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear), .match(match),
    .match_count(match_count), .cfg_err(cfg_err),
`ifdef SEQDET_LAST_POS_EN
    .last_pos(last_pos),
`endif
    .armed(armed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the accepted bits since the last (re)start, matched against the pattern tail.
  bit             q[$];
  logic [PAT_W-1:0] m_pat;
  int             m_len;
  bit             m_ov;
  bit             e_match, e_err, e_armed;
  int             e_cnt;

  typedef struct {
    bit rst, v, b, ld;
    logic [PAT_W-1:0] pat;
    logic [LW-1:0] len;
    bit ov, clr;
    bit x_match;
    int x_cnt;
    bit x_armed;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit hit;
    if (reset) begin
      q.delete(); m_pat = '0; m_len = 0; m_ov = 1'b1;
      e_match = 0; e_err = 0; e_armed = 0; e_cnt = 0;
      return;
    end
    hit = 0; e_err = 0;
    if (cfg_load) begin
      if (cfg_len >= 1 && cfg_len <= PAT_W) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len); m_ov = cfg_overlap; q.delete();
      end else begin
        e_err = 1;
      end
    end else if (in_valid && m_len != 0) begin
      q.push_back(in_bit);
      if (q.size() > PAT_W) void'(q.pop_front());
      if (q.size() >= m_len) begin
        hit = 1;
        for (int i = 0; i < m_len; i++)
          if (q[q.size()-1-i] != m_pat[i]) hit = 0;
      end
      if (hit && !m_ov) q.delete();
    end
    e_match = hit;
    if (cnt_clear) e_cnt = 0;
    else if (hit && e_cnt < CMAX) e_cnt++;
    e_armed = (m_len != 0) && (q.size() >= m_len);
  endtask

  // One clock: drive at the falling edge, let the model follow the rising edge, compare at the next falling edge.
  task automatic cyc(input bit rst, input bit v, input bit b, input bit ld,
                     input logic [PAT_W-1:0] pat, input logic [LW-1:0] len,
                     input bit ov, input bit clr);
    reset = rst; in_valid = v; in_bit = b; cfg_load = ld;
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cnt_clear = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("match", int'(match), int'(e_match));
    chk("match_count", int'(match_count), e_cnt);
    chk("cfg_err", int'(cfg_err), int'(e_err));
    chk("armed", int'(armed), int'(e_armed));
  endtask

  task automatic bit_in(input bit b);  cyc(0, 1, b, 0, '0, '0, 1, 0); endtask
  task automatic idle();               cyc(0, 0, 0, 0, '0, '0, 1, 0); endtask
  task automatic load(input logic [PAT_W-1:0] p, input logic [LW-1:0] l, input bit ov);
    cyc(0, 0, 0, 1, p, l, ov, 1);
  endtask
  task automatic bits4(input logic [3:0] s);
    for (int i = 3; i >= 0; i--) bit_in(s[i]);
  endtask

  initial begin
    // Pattern 0100, len 4, overlap: stream 0,1,0,0,1,0,0 hits after indices 3 and 6.
    tbl[0] = '{0,0,0,1, 8'h04, 4'd4, 1,0, 0,0,0};
    tbl[1] = '{0,1,0,0, 8'h00, 4'd0, 1,0, 0,0,0};
    tbl[2] = '{0,1,1,0, 8'h00, 4'd0, 1,0, 0,0,0};
    tbl[3] = '{0,1,0,0, 8'h00, 4'd0, 1,0, 0,0,0};
    tbl[4] = '{0,1,0,0, 8'h00, 4'd0, 1,0, 1,1,1};
    tbl[5] = '{0,1,1,0, 8'h00, 4'd0, 1,0, 0,1,1};
    tbl[6] = '{0,1,0,0, 8'h00, 4'd0, 1,0, 0,1,1};
    tbl[7] = '{0,1,0,0, 8'h00, 4'd0, 1,0, 1,2,1};
    tbl[8] = '{0,0,0,0, 8'h00, 4'd0, 1,0, 0,2,1};

    cyc(1, 0, 0, 0, '0, '0, 1, 0);
    chk("rst_match", int'(match), 0);
    chk("rst_count", int'(match_count), 0);
    chk("rst_armed", int'(armed), 0);
    bit_in(1'b1);
    chk("idle_no_match", int'(match), 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].v, tbl[i].b, tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].ov, tbl[i].clr);
      chk($sformatf("tbl%0d_match", i), int'(match), int'(tbl[i].x_match));
      chk($sformatf("tbl%0d_count", i), int'(match_count), tbl[i].x_cnt);
      chk($sformatf("tbl%0d_armed", i), int'(armed), int'(tbl[i].x_armed));
    end

    // Non-overlapping: second occurrence lacks a full refill.
    load(8'h04, 4'd4, 0);
    bits4(4'b0100);
    chk("novl_match", int'(match), 1);
    chk("novl_armed", int'(armed), 0);
    bit_in(1); bit_in(0); bit_in(0);
    chk("novl_count", int'(match_count), 1);

    // Illegal lengths while armed keep the old config.
    load(8'h04, 4'd4, 1);
    bits4(4'b0100);
    cyc(0, 0, 0, 1, 8'hFF, 4'd0, 0, 0);
    chk("len0_err", int'(cfg_err), 1);
    chk("len0_armed", int'(armed), 1);
    cyc(0, 1, 1, 1, 8'hFF, 4'd9, 0, 0);
    chk("len9_err", int'(cfg_err), 1);
    idle();
    chk("err_pulse_end", int'(cfg_err), 0);
    bit_in(1); bit_in(0); bit_in(0);
    chk("old_cfg_match", int'(match), 1);

    // Idle gap inside the pattern.
    load(8'h04, 4'd4, 1);
    bit_in(0); bit_in(1); bit_in(0);
    repeat (5) begin
      idle();
      chk("gap_no_match", int'(match), 0);
    end
    bit_in(0);
    chk("gap_match", int'(match), 1);
    chk("gap_count", int'(match_count), 1);

    // Saturation and clear-beats-hit.
    load(8'h01, 4'd1, 1);
    repeat (5) bit_in(1);
    chk("sat_count", int'(match_count), 3);
    cyc(0, 1, 1, 0, '0, '0, 1, 1);
    chk("clr_hit_match", int'(match), 1);
    chk("clr_hit_count", int'(match_count), 0);

    // Load and bit in the same cycle: the bit is dropped.
    cyc(0, 1, 1, 1, 8'h01, 4'd1, 1, 0);
    chk("load_drop", int'(match), 0);

    // Reset mid-stream discards the config.
    load(8'h04, 4'd4, 1);
    bits4(4'b0100);
    bit_in(1);
    cyc(1, 1, 0, 0, '0, '0, 1, 0);
    chk("midrst_armed", int'(armed), 0);
    chk("midrst_count", int'(match_count), 0);
    bits4(4'b0100);
    chk("midrst_no_match", int'(match), 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit rst, v, b, ld, ov, clr;
      logic [PAT_W-1:0] pat;
      logic [LW-1:0] len;
      rst = ($urandom_range(0, 499) == 0);
      ld  = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 3) != 0);
      b   = $urandom_range(0, 1);
      ov  = $urandom_range(0, 1);
      clr = ($urandom_range(0, 49) == 0);
      pat = PAT_W'($urandom);
      len = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(0, 15)) : LW'($urandom_range(1, 4));
      cyc(rst, v, b, ld, pat, len, ov, clr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised Mealy-style serial bit-sequence detector, successor to the fixed-pattern detector.
- Pattern, pattern length and overlap mode are runtime-programmable up to PAT_W bits.
- Adds an input-valid qualifier, a registered match pulse and a saturating match counter.
- Sits on a serial data path; match/match_count feed the status/interrupt logic.

Parameters:
PAT_W, 8, maximum pattern length in bits (2..32)
CNT_W, 8, match counter width
POS_W, 16, bit-position counter width (optional feature only)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_bit is accepted this cycle
in_bit  input  1  serial data bit, oldest-first
cfg_load  input  1  capture cfg_* this cycle
cfg_pattern  input  PAT_W  pattern; bit 0 = last bit received
cfg_len  input  $clog2(PAT_W+1)  active pattern length, legal 1..PAT_W
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cnt_clear  input  1  clear match_count
match  output  1  one-cycle pulse, registered
match_count  output  CNT_W  saturating number of matches
cfg_err  output  1  one-cycle pulse, illegal cfg_len rejected
armed  output  1  config valid and history full

Behaviour:
- Clock clk; reset is synchronous, active-high.
- Reset: state IDLE; match=0, match_count=0, cfg_err=0, armed=0; history=0; fill=0; pattern=0; len=0; overlap=1.
- FSM states:
  - IDLE: no legal config; bits ignored; match never asserts.
  - FILL: fill < len; collecting bits.
  - ARMED: fill == len; every accepted bit is compared.
- Legal cfg_load (1 <= cfg_len <= PAT_W): latch pattern/len/overlap, clear history and fill, go to FILL. Allowed from any state.
- Illegal cfg_load (cfg_len == 0 or > PAT_W): config unchanged, state unchanged, cfg_err=1 next cycle.
- cfg_load and in_valid in the same cycle: load wins; that bit is dropped.
- Accepted bit: hist_n = {hist[PAT_W-2:0], in_bit}; fill_n = min(fill+1, len).
- hit = (fill_n == len) && (hist_n[len-1:0] == pattern[len-1:0]), evaluated only on an accepted bit in FILL/ARMED.
- match <= hit: asserts exactly one cycle after the accepting edge, for exactly one cycle.
- No match when in_valid=0; history holds across idle gaps.
- Overlap=1: fill stays at len after a hit, so suffix bits can start the next match.
- Overlap=0: a hit clears fill to 0 (history contents don't care); state returns to FILL.
- match_count increments on hit and saturates at 2^CNT_W-1 (no wrap).
- cnt_clear zeroes match_count; cnt_clear together with a hit gives 0 (clear wins).
- armed = (state == ARMED), registered.
- Reset asserted mid-stream: everything returns to reset values next edge, including the loaded config.

Optional Feature:
- Macro SEQDET_LAST_POS_EN.
- Defined:
  - Adds output last_pos [POS_W-1:0] and an internal accepted-bit counter.
  - The counter starts at 0 after reset or a legal cfg_load, increments per accepted bit, and wraps modulo 2^POS_W.
  - last_pos is the index of the final bit of the latest match; it updates on the same edge as match. Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package seq_det_pkg:
  - state enum (S_IDLE, S_FILL, S_ARMED);
  - OVERLAP/NON_OVERLAP constants;
  - len-width helper function.
- One sub-module, seq_sat_counter (CNT_W, inc, clr, value; clear priority). It is reused for match_count.
- Compare/shift logic stays in the top module.

Test Plan:
- Load pattern 4'b0100, len=4, overlap=1; stream 0,1,0,0,1,0,0 -> match pulses one cycle after bit indices 3 and 6; match_count=2.
- Same stream with overlap=0 -> single match after index 3, then one after index 6 only if the full 4 bits are refilled (expect count=1).
- cfg_len=0 load while ARMED -> cfg_err pulses once; armed stays 1; detection continues with the old pattern.
- in_valid low for 5 cycles between bits 2 and 3 of 0100 -> match still fires once after bit 3 is accepted.
- CNT_W=2; produce 5 matches -> count reads 3; assert cnt_clear on the same cycle as a hit -> count 0.
- Reset asserted while ARMED mid-pattern -> next cycle: state IDLE, all outputs 0; bits without a new load produce no match.
